chunked_subtractor: RTL

CHUNKED_SUBTRACTOR -- requirements
Module: chunked_subtractor

---
 rtl/chunked_subtractor_if.sv | 12 +
 rtl/chunked_subtractor.sv | 57 +++++
 2 files changed

// File: rtl/chunked_subtractor_if.sv
// chunked_subtractor_if: start/operand request and busy/done/result response bundle
interface chunked_subtractor_if #(parameter int N = 32);
    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    modport master (output start, in1, in2, input busy, done, diff, bout);
    modport slave  (input start, in1, in2, output busy, done, diff, bout);
endinterface

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle unsigned subtractor, W bits per cycle, LSB chunk first
module chunked_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input logic                clk,
    input logic                rst_n,
    chunked_subtractor_if.slave bus
);
    localparam int C  = N / W;
    localparam int KW = C > 1 ? $clog2(C) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t         state, state_nx;
    logic [N-1:0]   a, b, diff;
    logic           borrow, done, bout, last;
    logic [KW-1:0]  k;
    logic [W:0]     chunk;
    // bit W of the widened difference is the outgoing borrow of this chunk
    always_comb begin
        chunk    = {1'b0, a[k*W +: W]} - {1'b0, b[k*W +: W]} - {{W{1'b0}}, borrow};
        last     = k == KW'(C - 1);
        state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            borrow <= 1'b0;
            k      <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && bus.start) begin
                a      <= bus.in1;
                b      <= bus.in2;
                borrow <= 1'b0;
                k      <= '0;
            end else if (state == RUN) begin
                diff[k*W +: W] <= chunk[W-1:0];
                borrow         <= chunk[W];
                k              <= k + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    bout <= chunk[W];
                end
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = done;
    assign bus.diff = diff;
    assign bus.bout = bout;
endmodule
